// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between instruction fetch (port 0)
// and data load/store (port 1), with MOC handshake, done pulse and timeout abort.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_rw,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_done,
  input  logic              req1_valid,
  input  logic              req1_rw,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [1:0]        grant,
  output logic              mem_enable,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_moc
);

  // state   | meaning
  // IDLE    | no owner, sample requests and pick a winner
  // ACCESS  | mem_enable high, waiting for MOC or timeout
  // RELEASE | done/err pulse, then wait for MOC to drop
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  localparam logic [7:0] lastCount = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic       lastGrant;
  logic [7:0] counter;
  logic       pickOne;

  // Port 1 wins when it is the only requester, or on a tie when port 0 went last.
  assign pickOne = req1_valid & (~req0_valid | ~lastGrant);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= 2'b00;
      mem_enable <= 1'b0;
      mem_rw     <= 1'b1;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
      err        <= 1'b0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      lastGrant  <= 1'b1;
      counter    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            if (pickOne) begin
              mem_addr  <= req1_addr;
              mem_rw    <= req1_rw;
              mem_wdata <= req1_wdata;
              grant     <= 2'b10;
            end else begin
              mem_addr  <= req0_addr;
              mem_rw    <= req0_rw;
              mem_wdata <= req0_wdata;
              grant     <= 2'b01;
            end
            lastGrant  <= pickOne;
            mem_enable <= 1'b1;
            counter    <= 8'd0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          // MOC takes priority over a coincident timeout.
          if (mem_moc) begin
            if (mem_rw) rdata <= mem_rdata;
            err        <= 1'b0;
            req0_done  <= grant[0];
            req1_done  <= grant[1];
            mem_enable <= 1'b0;
            counter    <= 8'd0;
            state      <= RELEASE;
          end else if (counter == lastCount) begin
            rdata      <= '0;
            err        <= 1'b1;
            req0_done  <= grant[0];
            req1_done  <= grant[1];
            mem_enable <= 1'b0;
            counter    <= 8'd0;
            state      <= RELEASE;
          end else if (counter != 8'hFF) begin
            counter <= counter + 8'd1;
          end
        end
        RELEASE: begin
          req0_done <= 1'b0;
          req1_done <= 1'b0;
          err       <= 1'b0;
          // A stuck-high MOC must not hold the port forever.
          if (!mem_moc || counter == lastCount) begin
            grant <= 2'b00;
            state <= IDLE;
          end else if (counter != 8'hFF) begin
            counter <= counter + 8'd1;
          end
        end
        default: begin
          state      <= IDLE;
          grant      <= 2'b00;
          mem_enable <= 1'b0;
          req0_done  <= 1'b0;
          req1_done  <= 1'b0;
          err        <= 1'b0;
        end
      endcase
    end
  end

endmodule
